matrix_gen_engine: RTL and testbench
====================================

Name: matrix_gen_engine

Overview:
- Parametrised successor to the UART-driven matrix generator.
- Accepts an already-parsed generation command (count, rows, cols) over a valid/ready handshake.
- Per matrix: allocates a slot from the matrix manager, fills it with bounded pseudo-random values from an internal LFSR, then commits it.
- Sits between the command parser and the matrix manager/BRAM. Display is handled downstream.

Parameters:
- ELEMENT_WIDTH, 8, stored element width (bits).
- ADDR_WIDTH, 10, BRAM address width.
- DIM_WIDTH, 5, width of m/n fields (max dimension 2^DIM_WIDTH-1).
- CNT_WIDTH, 8, width of matrix-count fields.
- LFSR_SEED, 16'hACE1, LFSR reset value. A value of 0 is illegal and is replaced by 16'h0001.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- abort  in  1  synchronous abort; returns the block to IDLE.
- cfg_max_dim  in  DIM_WIDTH  largest legal m/n.
- cfg_max_value  in  ELEMENT_WIDTH  largest generated value (inclusive).
- cfg_max_count  in  CNT_WIDTH  largest legal count.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_count  in  CNT_WIDTH  number of matrices to generate.
- cmd_m, cmd_n  in  DIM_WIDTH  dimensions.
- alloc_req  out  1  allocation request (level).
- alloc_m, alloc_n  out  DIM_WIDTH  requested dimensions.
- alloc_valid  in  1  one-cycle grant.
- alloc_fail  in  1  one-cycle refusal.
- alloc_slot  in  4  granted slot.
- alloc_addr  in  ADDR_WIDTH  granted base address.
- mem_wr_en  out  1  write strobe.
- mem_wr_addr  out  ADDR_WIDTH  write address.
- mem_wr_data  out  ELEMENT_WIDTH  write data.
- commit_req  out  1  one-cycle commit pulse.
- commit_slot  out  4  committed slot.
- commit_m, commit_n  out  DIM_WIDTH  committed dimensions.
- commit_addr  out  ADDR_WIDTH  committed base address.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at successful end of a command.
- error_code  out  4  0 none, 1 dim range, 2 count range, 3 alloc fail, 4 aborted. Held until the next accepted command.

Behaviour:
- Reset values:
  - all outputs 0, except cmd_ready=1;
  - state IDLE;
  - LFSR=LFSR_SEED.
- LFSR:
  - 16-bit Galois, taps 16'hB400; advances every cycle regardless of state (including while ready).
- Value draw:
  - mask = smallest 2^k-1 that is >= cfg_max_value (computed combinationally);
  - candidate = lfsr[ELEMENT_WIDTH-1:0] & mask;
  - if candidate > cfg_max_value, the draw is rejected: no write that cycle, retry next cycle;
  - cfg_max_value=0 always yields 0 with no rejections.
- State IDLE:
  - accept when cmd_valid && cmd_ready;
  - latch count/m/n and clear error_code;
  - go to CHECK.
- State CHECK (1 cycle):
  - m==0, n==0, m>cfg_max_dim or n>cfg_max_dim → error 1, go to ERR;
  - else count==0 or count>cfg_max_count → error 2, go to ERR (dimension checks take priority);
  - else total = m*n (2*DIM_WIDTH bits), go to ALLOC.
- State ALLOC:
  - alloc_req held high, alloc_m/n driven;
  - alloc_valid → latch slot/addr, drop alloc_req, clear element index, go to FILL;
  - alloc_fail → error 3, go to ERR;
  - alloc_valid and alloc_fail in the same cycle: valid wins.
- State FILL:
  - each non-rejected cycle: mem_wr_en=1, mem_wr_addr=base+idx, mem_wr_data=candidate, idx++;
  - registered outputs, so the write appears one cycle after the draw;
  - exactly total writes, at addresses base..base+total-1, row-major;
  - after the last write, go to COMMIT.
- State COMMIT (1 cycle):
  - commit_req=1 with slot/m/n/addr;
  - remaining-- ; if remaining>0 go to ALLOC (new allocation), else go to FIN.
- State FIN: pulse done, go to IDLE.
- State ERR: 1 cycle, go to IDLE; error_code persists.
- abort:
  - in any non-IDLE state: deassert alloc_req/mem_wr_en/commit_req next cycle, error 4, go to IDLE;
  - matrices already committed stay committed;
  - a partly filled matrix is never committed;
  - abort in IDLE is ignored;
  - abort has priority over all other transitions.
- Minimum latency for a 1×1, count-1 command with an immediate grant and no rejection: accept → CHECK → ALLOC → FILL → COMMIT → FIN; done 5 cycles after accept.
- Counters are sized so that total up to (2^DIM_WIDTH-1)^2 never wraps.

Optional Feature:
- Macro: MATGEN_SIGNED_EN.
- Defined:
  - draw range is symmetric, -cfg_max_value..+cfg_max_value;
  - draw: magnitude as above, sign = lfsr[15];
  - result is two's-complement in ELEMENT_WIDTH;
  - -0 is written as 0.
- Undefined: values are unsigned, 0..cfg_max_value.

Test Plan:
- cfg_max_dim=5, cfg_max_value=9, cmd 1/2/3, alloc_valid after 2 cycles with addr=0x40, slot=3 → 6 writes at 0x40..0x45, each value ≤9; one commit_req with slot 3, 2×3, addr 0x40; done pulse.
- cmd count=3, m=n=2, grants at 0x00/0x10/0x20 → 3 alloc_req episodes, 12 writes, 3 commits in order, one done.
- cmd m=0 or m=6 with cfg_max_dim=5 → error_code=1, no alloc_req, back to cmd_ready=1; cmd count=0 → error_code=2.
- cfg_max_value=4 (mask 7) over 200 draws → no written value >4; at least one rejection cycle observed; cfg_max_value=0 → all writes 0.
- Second matrix answered with alloc_fail → error_code=3, first commit kept, no second commit. Abort mid-FILL → writes stop within 1 cycle, error_code=4, no commit.
- Assert rst_n low mid-FILL → all outputs 0 and cmd_ready=1 immediately; LFSR returns to 16'hACE1.

Source files
------------

// File: rtl/matrix_gen_engine.sv
// Matrix generation engine: takes a parsed (count, m, n) command, allocates slots and fills them with bounded LFSR values.
// Optional build macro MATGEN_SIGNED_EN selects a symmetric signed value range instead of 0..cfg_max_value.
module matrix_gen_engine #(
   parameter int          ELEMENT_WIDTH = 8,
   parameter int          ADDR_WIDTH    = 10,
   parameter int          DIM_WIDTH     = 5,
   parameter int          CNT_WIDTH     = 8,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     abort,
   input  logic [DIM_WIDTH-1:0]     cfg_max_dim,
   input  logic [ELEMENT_WIDTH-1:0] cfg_max_value,
   input  logic [CNT_WIDTH-1:0]     cfg_max_count,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [CNT_WIDTH-1:0]     cmd_count,
   input  logic [DIM_WIDTH-1:0]     cmd_m,
   input  logic [DIM_WIDTH-1:0]     cmd_n,
   output logic                     alloc_req,
   output logic [DIM_WIDTH-1:0]     alloc_m,
   output logic [DIM_WIDTH-1:0]     alloc_n,
   input  logic                     alloc_valid,
   input  logic                     alloc_fail,
   input  logic [3:0]               alloc_slot,
   input  logic [ADDR_WIDTH-1:0]    alloc_addr,
   output logic                     mem_wr_en,
   output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
   output logic [ELEMENT_WIDTH-1:0] mem_wr_data,
   output logic                     commit_req,
   output logic [3:0]               commit_slot,
   output logic [DIM_WIDTH-1:0]     commit_m,
   output logic [DIM_WIDTH-1:0]     commit_n,
   output logic [ADDR_WIDTH-1:0]    commit_addr,
   output logic                     busy,
   output logic                     done,
   output logic [3:0]               error_code
);

   localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam int          TOT_W = 2 * DIM_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_ALLOC, S_FILL, S_COMMIT, S_FIN, S_ERR
   } state_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Smearing every set bit downwards gives the smallest all-ones mask covering the value.
   function automatic logic [ELEMENT_WIDTH-1:0] value_mask(input logic [ELEMENT_WIDTH-1:0] mx);
      logic [ELEMENT_WIDTH-1:0] m;
      m = mx;
      for (int i = 1; i < ELEMENT_WIDTH; i++) m = m | (mx >> i);
      return m;
   endfunction

`ifdef MATGEN_SIGNED_EN
   function automatic logic [ELEMENT_WIDTH-1:0] signed_value(input logic [ELEMENT_WIDTH-1:0] mag,
                                                             input logic                     sgn);
      logic signed [ELEMENT_WIDTH-1:0] s_val;
      s_val = signed'(mag);
      if (sgn) s_val = -s_val;
      return s_val;
   endfunction
`endif

   state_t                   state_q, state_d;
   logic [15:0]              lfsr_q, lfsr_d;
   logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
   logic [DIM_WIDTH-1:0]     m_q, m_d, n_q, n_d;
   logic [TOT_W-1:0]         total_q, total_d, idx_q, idx_d;
   logic [3:0]               slot_q, slot_d, err_q, err_d;
   logic [ADDR_WIDTH-1:0]    base_q, base_d, wr_addr_q, wr_addr_d;
   logic [ELEMENT_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                     alloc_req_q, alloc_req_d, wr_en_q, wr_en_d;
   logic                     commit_req_q, commit_req_d, done_q, done_d;
   logic                     cmd_ready_q, cmd_ready_d, busy_q, busy_d;
   logic [ELEMENT_WIDTH-1:0] cand, wr_val;
   logic                     draw_ok;

   always_comb begin
      cand    = lfsr_q[ELEMENT_WIDTH-1:0] & value_mask(cfg_max_value);
      draw_ok = (cand <= cfg_max_value);
`ifdef MATGEN_SIGNED_EN
      wr_val  = signed_value(cand, lfsr_q[15]);
`else
      wr_val  = cand;
`endif

      state_d      = state_q;
      lfsr_d       = lfsr_next(lfsr_q);
      cnt_d        = cnt_q;
      m_d          = m_q;
      n_d          = n_q;
      total_d      = total_q;
      idx_d        = idx_q;
      slot_d       = slot_q;
      base_d       = base_q;
      err_d        = err_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      commit_req_d = 1'b0;
      done_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               cnt_d   = cmd_count;
               m_d     = cmd_m;
               n_d     = cmd_n;
               err_d   = 4'd0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (m_q == '0 || n_q == '0 || m_q > cfg_max_dim || n_q > cfg_max_dim) begin
               err_d   = 4'd1;
               state_d = S_ERR;
            end else if (cnt_q == '0 || cnt_q > cfg_max_count) begin
               err_d   = 4'd2;
               state_d = S_ERR;
            end else begin
               total_d = TOT_W'(m_q) * TOT_W'(n_q);
               state_d = S_ALLOC;
            end
         end
         S_ALLOC: begin
            if (alloc_valid) begin
               slot_d  = alloc_slot;
               base_d  = alloc_addr;
               idx_d   = '0;
               state_d = S_FILL;
            end else if (alloc_fail) begin
               err_d   = 4'd3;
               state_d = S_ERR;
            end
         end
         S_FILL: begin
            // A rejected draw just skips this cycle; the LFSR moves on and the next cycle retries.
            if (draw_ok) begin
               wr_en_d   = 1'b1;
               wr_addr_d = base_q + ADDR_WIDTH'(idx_q);
               wr_data_d = wr_val;
               idx_d     = idx_q + TOT_W'(1);
               if (idx_q == total_q - TOT_W'(1)) state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            commit_req_d = 1'b1;
            cnt_d        = cnt_q - CNT_WIDTH'(1);
            state_d      = (cnt_q > CNT_WIDTH'(1)) ? S_ALLOC : S_FIN;
         end
         S_FIN: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort && state_q != S_IDLE) begin
         state_d      = S_IDLE;
         err_d        = 4'd4;
         wr_en_d      = 1'b0;
         commit_req_d = 1'b0;
         done_d       = 1'b0;
      end

      alloc_req_d = (state_d == S_ALLOC);
      cmd_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         lfsr_q       <= SEED;
         cnt_q        <= '0;
         m_q          <= '0;
         n_q          <= '0;
         total_q      <= '0;
         idx_q        <= '0;
         slot_q       <= '0;
         base_q       <= '0;
         err_q        <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         commit_req_q <= 1'b0;
         done_q       <= 1'b0;
         alloc_req_q  <= 1'b0;
         cmd_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         cnt_q        <= cnt_d;
         m_q          <= m_d;
         n_q          <= n_d;
         total_q      <= total_d;
         idx_q        <= idx_d;
         slot_q       <= slot_d;
         base_q       <= base_d;
         err_q        <= err_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         commit_req_q <= commit_req_d;
         done_q       <= done_d;
         alloc_req_q  <= alloc_req_d;
         cmd_ready_q  <= cmd_ready_d;
         busy_q       <= busy_d;
      end
   end

   // Slot/base stay stable through the commit pulse: the next grant can only land a cycle later.
   assign cmd_ready   = cmd_ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error_code  = err_q;
   assign alloc_req   = alloc_req_q;
   assign alloc_m     = m_q;
   assign alloc_n     = n_q;
   assign mem_wr_en   = wr_en_q;
   assign mem_wr_addr = wr_addr_q;
   assign mem_wr_data = wr_data_q;
   assign commit_req  = commit_req_q;
   assign commit_slot = slot_q;
   assign commit_m    = m_q;
   assign commit_n    = n_q;
   assign commit_addr = base_q;

endmodule

// File: tb/tb_matrix_gen_engine.sv
// Scoreboard bench for matrix_gen_engine: grants push expected writes/commits, a negedge monitor pops and compares.
module tb_matrix_gen_engine;
   localparam int EW = 8;
   localparam int AW = 10;
   localparam int DW = 5;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          abort = 1'b0;
   logic [DW-1:0] cfg_max_dim = 5'd5;
   logic [EW-1:0] cfg_max_value = 8'd9;
   logic [CW-1:0] cfg_max_count = 8'd10;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [CW-1:0] cmd_count = '0;
   logic [DW-1:0] cmd_m = '0, cmd_n = '0;
   logic          alloc_req;
   logic [DW-1:0] alloc_m, alloc_n;
   logic          alloc_valid = 1'b0, alloc_fail = 1'b0;
   logic [3:0]    alloc_slot = '0;
   logic [AW-1:0] alloc_addr = '0;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_addr;
   logic [EW-1:0] mem_wr_data;
   logic          commit_req;
   logic [3:0]    commit_slot;
   logic [DW-1:0] commit_m, commit_n;
   logic [AW-1:0] commit_addr;
   logic          busy, done;
   logic [3:0]    error_code;

   matrix_gen_engine dut (
      .clk(clk), .rst_n(rst_n), .abort(abort),
      .cfg_max_dim(cfg_max_dim), .cfg_max_value(cfg_max_value), .cfg_max_count(cfg_max_count),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_count(cmd_count), .cmd_m(cmd_m), .cmd_n(cmd_n),
      .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n), .alloc_valid(alloc_valid),
      .alloc_fail(alloc_fail), .alloc_slot(alloc_slot), .alloc_addr(alloc_addr),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m), .commit_n(commit_n),
      .commit_addr(commit_addr), .busy(busy), .done(done), .error_code(error_code)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Reference LFSR: Galois, right shift, taps 0xB400, free-running from reset.
   logic [15:0] lfsr_m, lfsr_prev;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_m    <= 16'hACE1;
         lfsr_prev <= 16'hACE1;
      end else begin
         lfsr_prev <= lfsr_m;
         lfsr_m    <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
      end
   end

   // Returns the accepted value, or -1 when the draw must be rejected.
   function automatic int draw(input logic [15:0] l, input int mx);
      int k, c;
      k = 0;
      while (((1 << k) - 1) < mx) k++;
      c = int'(l[7:0]) & ((1 << k) - 1);
      return (c > mx) ? -1 : c;
   endfunction

   typedef struct {
      logic [3:0]    slot;
      logic [DW-1:0] m, n;
      logic [AW-1:0] addr;
   } cm_t;

   logic [AW-1:0] wr_q[$];
   cm_t           cm_q[$];
   int n_wr = 0, n_cm = 0, n_done = 0, n_ep = 0, n_rej = 0, n_nz = 0;
   int last_wr = 0, done_cyc = 0, accept_cyc = 0;
   bit last_ok = 0;
   logic alloc_prev = 1'b0;

   always @(negedge clk) begin : mon
      int  e;
      cm_t c;
      if (rst_n) begin
         if (mem_wr_en) begin
            n_wr++;
            if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
            else chk("wr_addr", 32'(mem_wr_addr), 32'(wr_q.pop_front()));
            e = draw(lfsr_prev, int'(cfg_max_value));
            chk("wr_data", 32'(mem_wr_data), e);
            if (mem_wr_data != '0) n_nz++;
            if (last_ok && (cyc - last_wr) > 1) n_rej++;
            last_wr = cyc;
            last_ok = 1;
         end
         if (commit_req) begin
            n_cm++;
            last_ok = 0;
            if (cm_q.size() == 0) chk("commit_unexpected", 1, 0);
            else begin
               c = cm_q.pop_front();
               chk("commit_slot", 32'(commit_slot), 32'(c.slot));
               chk("commit_m", 32'(commit_m), 32'(c.m));
               chk("commit_n", 32'(commit_n), 32'(c.n));
               chk("commit_addr", 32'(commit_addr), 32'(c.addr));
            end
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (alloc_req && !alloc_prev) n_ep++;
         alloc_prev = alloc_req;
      end else begin
         alloc_prev = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input int budget);
      int t = 0;
      while (!cmd_ready && t < budget) begin
         tick(1);
         t++;
      end
      if (!cmd_ready) chk("idle_timeout", 0, 1);
      tick(1);
   endtask

   task automatic send_cmd(input int c, input int m, input int n);
      wait_idle(200);
      cmd_count = CW'(c);
      cmd_m     = DW'(m);
      cmd_n     = DW'(n);
      cmd_valid = 1'b1;
      tick(1);
      cmd_valid  = 1'b0;
      accept_cyc = cyc;
   endtask

   task automatic grant(input int slot, input int addr, input int m, input int n,
                        input int dly, input bit fail);
      int  t = 0;
      cm_t c;
      while (!alloc_req && t < 500) begin
         tick(1);
         t++;
      end
      if (!alloc_req) chk("alloc_timeout", 0, 1);
      chk("alloc_m", 32'(alloc_m), m);
      chk("alloc_n", 32'(alloc_n), n);
      tick(dly);
      if (!fail) begin
         for (int i = 0; i < m * n; i++) wr_q.push_back(AW'(addr + i));
         c.slot = 4'(slot);
         c.m    = DW'(m);
         c.n    = DW'(n);
         c.addr = AW'(addr);
         cm_q.push_back(c);
      end
      alloc_slot  = 4'(slot);
      alloc_addr  = AW'(addr);
      alloc_valid = !fail;
      alloc_fail  = fail;
      tick(1);
      alloc_valid = 1'b0;
      alloc_fail  = 1'b0;
   endtask

   typedef struct { int c; int m; int n; int ec; } err_case_t;
   err_case_t ecases[6] = '{'{1, 0, 2, 1}, '{1, 6, 2, 1}, '{1, 2, 6, 1},
                            '{0, 2, 2, 2}, '{11, 2, 2, 2}, '{0, 0, 2, 1}};

   initial begin
      int w0, c0, d0, e0, r0, z0, t;
      tick(3);
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_alloc_req", 32'(alloc_req), 0);
      chk("rst_wr_en", 32'(mem_wr_en), 0);
      chk("rst_commit", 32'(commit_req), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_error", 32'(error_code), 0);
      rst_n = 1'b1;
      tick(2);

      // 2x3 single matrix, grant two cycles late
      w0 = n_wr; c0 = n_cm; d0 = n_done;
      send_cmd(1, 2, 3);
      grant(3, 'h40, 2, 3, 2, 0);
      wait_idle(500);
      chk("t1_writes", n_wr - w0, 6);
      chk("t1_commits", n_cm - c0, 1);
      chk("t1_done", n_done - d0, 1);
      chk("t1_error", 32'(error_code), 0);
      chk("t1_wr_q_empty", wr_q.size(), 0);

      // 1x1 minimum latency with full value range (no rejections possible)
      cfg_max_value = 8'd255;
      d0 = n_done;
      send_cmd(1, 1, 1);
      grant(5, 'h3F0, 1, 1, 0, 0);
      wait_idle(100);
      chk("lat_done", n_done - d0, 1);
      chk("lat_cycles", done_cyc - accept_cyc, 5);

      // three 2x2 matrices
      cfg_max_value = 8'd9;
      w0 = n_wr; c0 = n_cm; d0 = n_done; e0 = n_ep;
      send_cmd(3, 2, 2);
      for (int i = 0; i < 3; i++) grant(i, i * 'h10, 2, 2, 1, 0);
      wait_idle(500);
      chk("t2_alloc_episodes", n_ep - e0, 3);
      chk("t2_writes", n_wr - w0, 12);
      chk("t2_commits", n_cm - c0, 3);
      chk("t2_done", n_done - d0, 1);

      // range errors
      e0 = n_ep;
      foreach (ecases[i]) begin
         send_cmd(ecases[i].c, ecases[i].m, ecases[i].n);
         wait_idle(50);
         chk("err_code", 32'(error_code), ecases[i].ec);
         chk("err_ready", 32'(cmd_ready), 1);
      end
      chk("err_no_alloc", n_ep - e0, 0);

      // mask 7 vs max 4 over 200 draws
      cfg_max_value = 8'd4;
      w0 = n_wr; r0 = n_rej;
      send_cmd(8, 5, 5);
      for (int i = 0; i < 8; i++) grant(i, i * 32, 5, 5, 1, 0);
      wait_idle(2000);
      chk("t4_writes", n_wr - w0, 200);
      chk("t4_rejection_seen", 32'(n_rej > r0), 1);
      chk("t4_wr_q_empty", wr_q.size(), 0);

      cfg_max_value = 8'd0;
      w0 = n_wr; z0 = n_nz;
      send_cmd(1, 3, 3);
      grant(9, 'h300, 3, 3, 0, 0);
      wait_idle(200);
      chk("zero_writes", n_wr - w0, 9);
      chk("zero_nonzero", n_nz - z0, 0);

      // second allocation refused
      cfg_max_value = 8'd9;
      w0 = n_wr; c0 = n_cm; d0 = n_done;
      send_cmd(2, 2, 2);
      grant(1, 'h80, 2, 2, 1, 0);
      grant(2, 'h90, 2, 2, 1, 1);
      wait_idle(200);
      chk("fail_error", 32'(error_code), 3);
      chk("fail_commits", n_cm - c0, 1);
      chk("fail_writes", n_wr - w0, 4);
      chk("fail_done", n_done - d0, 0);

      // abort mid-fill
      cfg_max_value = 8'd255;
      w0 = n_wr; c0 = n_cm;
      send_cmd(1, 5, 5);
      grant(4, 'h100, 5, 5, 0, 0);
      t = 0;
      while (n_wr - w0 < 5 && t < 200) begin tick(1); t++; end
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("abort_wr_stop", 32'(mem_wr_en), 0);
      chk("abort_error", 32'(error_code), 4);
      chk("abort_ready", 32'(cmd_ready), 1);
      w0 = n_wr;
      tick(4);
      chk("abort_no_more_wr", n_wr - w0, 0);
      chk("abort_no_commit", n_cm - c0, 0);
      wr_q.delete();
      cm_q.delete();

      // reset mid-fill
      w0 = n_wr;
      send_cmd(1, 4, 4);
      grant(6, 'h200, 4, 4, 0, 0);
      t = 0;
      while (n_wr - w0 < 3 && t < 200) begin tick(1); t++; end
      rst_n = 1'b0;
      #1;
      chk("rst2_cmd_ready", 32'(cmd_ready), 1);
      chk("rst2_wr_en", 32'(mem_wr_en), 0);
      chk("rst2_wr_addr", 32'(mem_wr_addr), 0);
      chk("rst2_wr_data", 32'(mem_wr_data), 0);
      chk("rst2_busy", 32'(busy), 0);
      chk("rst2_alloc_req", 32'(alloc_req), 0);
      chk("rst2_error", 32'(error_code), 0);
      wr_q.delete();
      cm_q.delete();
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // after reset the draws must follow the LFSR from its seed again
      w0 = n_wr; c0 = n_cm;
      send_cmd(1, 1, 2);
      grant(7, 'h10, 1, 2, 0, 0);
      wait_idle(100);
      chk("post_rst_writes", n_wr - w0, 2);
      chk("post_rst_commit", n_cm - c0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
